// File: rtl/sram_wb_bridge.sv
// Wishbone classic + pipelined fetch bridge in front of a dual-port SRAM macro; every SRAM-side signal is registered.
// Optional build macro SRAM_BRIDGE_HAZARD_EN stalls a fetch that collides with a same-word port-0 write.
`timescale 1ns/1ps

module sram_wb_bridge #(
    parameter int          ADDR_WIDTH = 9,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic                  if_req_i,
    input  logic [31:0]           if_adr_i,
    output logic                  if_ready_o,
    output logic                  if_valid_o,
    output logic                  if_err_o,
    output logic [31:0]           if_data_o,
    output logic                  sram_cs0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    input  logic [31:0]           sram_dout0,
    output logic                  sram_cs1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [31:0]           sram_dout1
);
    localparam int TAG_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_t;

    logic                  wb_in_range;
    logic                  if_in_range;
    logic [ADDR_WIDTH-1:0] wb_word;
    logic [ADDR_WIDTH-1:0] if_word;
    logic                  unused_adr_lsbs;

    assign wb_in_range     = (wb_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign if_in_range     = (if_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign wb_word         = wb_adr_i[ADDR_WIDTH+1:2];
    assign if_word         = if_adr_i[ADDR_WIDTH+1:2];
    assign unused_adr_lsbs = ^{wb_adr_i[1:0], if_adr_i[1:0]};

    // ---------------- Port 0: Wishbone classic slave ----------------
    state_t                state_reg, state_next;
    logic                  cs0_reg, cs0_next;
    logic                  web0_reg, web0_next;
    logic [3:0]            wmask0_reg, wmask0_next;
    logic [ADDR_WIDTH-1:0] addr0_reg, addr0_next;
    logic [31:0]           din0_reg, din0_next;
    logic [31:0]           dat_reg, dat_next;
    logic                  ack_reg, ack_next;
    logic                  err_reg, err_next;

    always_comb begin
        state_next  = state_reg;
        cs0_next    = 1'b0;
        web0_next   = web0_reg;
        wmask0_next = wmask0_reg;
        addr0_next  = addr0_reg;
        din0_next   = din0_reg;
        dat_next    = dat_reg;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (wb_in_range) begin
                        cs0_next    = 1'b1;
                        web0_next   = ~wb_we_i;
                        wmask0_next = wb_we_i ? wb_sel_i : 4'b0000;
                        addr0_next  = wb_word;
                        din0_next   = wb_dat_i;
                        state_next  = ST_ISSUE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_ACK;
                    end
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                // dout0 is only valid around this edge, so it is captured here or never
                if (web0_reg) begin
                    dat_next = sram_dout0;
                end
                ack_next   = wb_cyc_i;
                state_next = ST_ACK;
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cs0_reg    <= 1'b0;
            web0_reg   <= 1'b0;
            wmask0_reg <= 4'b0000;
            addr0_reg  <= '0;
            din0_reg   <= 32'h0;
            dat_reg    <= 32'h0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cs0_reg    <= cs0_next;
            web0_reg   <= web0_next;
            wmask0_reg <= wmask0_next;
            addr0_reg  <= addr0_next;
            din0_reg   <= din0_next;
            dat_reg    <= dat_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
        end
    end

    assign sram_cs0    = cs0_reg;
    assign sram_web0   = web0_reg;
    assign sram_wmask0 = wmask0_reg;
    assign sram_addr0  = addr0_reg;
    assign sram_din0   = din0_reg;
    assign wb_dat_o    = dat_reg;
    assign wb_ack_o    = ack_reg;
    assign wb_err_o    = err_reg;

    // ---------------- Port 1: fetch pipeline ----------------
    logic                  ready_reg;
    logic                  accept;
    logic                  cs1_reg;
    logic [ADDR_WIDTH-1:0] addr1_reg;
    logic                  s1_valid_reg, s1_err_reg;
    logic                  s2_valid_reg, s2_err_reg;
    logic                  if_valid_reg, if_err_reg;
    logic [31:0]           if_data_reg;

`ifdef SRAM_BRIDGE_HAZARD_EN
    logic hazard;
    // Only the cycle in which the port-0 write is being registered can collide
    assign hazard     = (state_reg == ST_IDLE) && wb_cyc_i && wb_stb_i && wb_we_i
                        && wb_in_range && (wb_word == if_word);
    assign if_ready_o = ready_reg & ~hazard;
`else
    assign if_ready_o = ready_reg;
`endif

    assign accept = if_req_i & if_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg    <= 1'b0;
            cs1_reg      <= 1'b0;
            addr1_reg    <= '0;
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_err_reg   <= 1'b0;
            if_valid_reg <= 1'b0;
            if_err_reg   <= 1'b0;
            if_data_reg  <= 32'h0;
        end else begin
            ready_reg    <= 1'b1;
            cs1_reg      <= accept & if_in_range;
            if (accept && if_in_range) begin
                addr1_reg <= if_word;
            end
            s1_valid_reg <= accept & if_in_range;
            s1_err_reg   <= accept & ~if_in_range;
            s2_valid_reg <= s1_valid_reg;
            s2_err_reg   <= s1_err_reg;
            if_valid_reg <= s2_valid_reg;
            if_err_reg   <= s2_err_reg;
            if (s2_valid_reg) begin
                if_data_reg <= sram_dout1;
            end
        end
    end

    assign sram_cs1   = cs1_reg;
    assign sram_addr1 = addr1_reg;
    assign if_valid_o = if_valid_reg;
    assign if_err_o   = if_err_reg;
    assign if_data_o  = if_data_reg;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Scoreboard bench for sram_wb_bridge: stimulus pushes expected responses, a negedge monitor pops and compares.
// Includes a behavioural SRAM whose dout is only valid from the negedge to just after the next posedge.
`timescale 1ns/1ps

module tb_sram_wb_bridge;
    localparam int          AW   = 9;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0]   wb_adr_i, wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic          if_req_i;
    logic [31:0]   if_adr_i;
    logic          if_ready_o, if_valid_o, if_err_o;
    logic [31:0]   if_data_o;
    logic          sram_cs0, sram_web0;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [31:0]   sram_din0;
    logic [31:0]   sram_dout0;
    logic          sram_cs1;
    logic [AW-1:0] sram_addr1;
    logic [31:0]   sram_dout1;

    sram_wb_bridge #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_ready_o(if_ready_o),
        .if_valid_o(if_valid_o), .if_err_o(if_err_o), .if_data_o(if_data_o),
        .sram_cs0(sram_cs0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_cs1(sram_cs1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    // SRAM model: command captured at posedge, executed at the following negedge
    logic [31:0] mem [0:(1<<AW)-1];
    initial begin : sram_model
        logic          p0, p0_we, p1;
        logic [3:0]    p0_mask;
        logic [AW-1:0] p0_a, p1_a;
        logic [31:0]   p0_d;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        sram_dout0 = 32'hBAD0_0BAD;
        sram_dout1 = 32'hBAD1_1BAD;
        forever begin
            @(posedge clk);
            p0 = sram_cs0; p0_we = ~sram_web0; p0_mask = sram_wmask0;
            p0_a = sram_addr0; p0_d = sram_din0;
            p1 = sram_cs1; p1_a = sram_addr1;
            #1;
            sram_dout0 = 32'hBAD0_0BAD;
            sram_dout1 = 32'hBAD1_1BAD;
            @(negedge clk);
            if (p0) begin
                if (p0_we) begin
                    for (int b = 0; b < 4; b++)
                        if (p0_mask[b]) mem[p0_a][8*b +: 8] = p0_d[8*b +: 8];
                end else begin
                    sram_dout0 = mem[p0_a];
                end
            end
            if (p1) sram_dout1 = mem[p1_a];
        end
    end

    typedef struct {
        int          kind;   // 0 = ack/valid, 1 = err
        logic [31:0] data;
        int          cyc;
        logic        chk;
    } exp_t;

    exp_t wb_q[$];
    exp_t if_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cs0_count = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cnt);
        end
    endtask

    exp_t wb_e, if_e;
    always @(negedge clk) begin
        if (sram_cs0) cs0_count <= cs0_count + 1;
        if (wb_ack_o || wb_err_o) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected_strobe", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
            end else begin
                wb_e = wb_q.pop_front();
                check("wb_kind", 32'(wb_err_o), 32'(wb_e.kind));
                check("wb_cycle", cnt, wb_e.cyc);
                if (wb_e.chk) check("wb_data", wb_dat_o, wb_e.data);
            end
        end
        if (if_valid_o || if_err_o) begin
            if (if_q.size() == 0) begin
                check("if_unexpected_strobe", {30'b0, if_valid_o, if_err_o}, 32'h0);
            end else begin
                if_e = if_q.pop_front();
                check("if_kind", 32'(if_err_o), 32'(if_e.kind));
                check("if_cycle", cnt, if_e.cyc);
                if (if_e.chk) check("if_data", if_data_o, if_e.data);
            end
        end
    end

    task automatic push_wb(input int kind, input logic [31:0] d, input int cyc, input logic chk);
        exp_t e;
        e.kind = kind; e.data = d; e.cyc = cyc; e.chk = chk;
        wb_q.push_back(e);
    endtask

    task automatic push_if(input int kind, input logic [31:0] d, input int cyc);
        exp_t e;
        e.kind = kind; e.data = d; e.cyc = cyc; e.chk = (kind == 0);
        if_q.push_back(e);
    endtask

    task automatic wait_wb_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) seen = 1'b1;
        end
        check({nm, "_terminated"}, 32'(seen), 32'h1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_go(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int kind, input logic [31:0] exp_d,
                         input string nm);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        push_wb(kind, exp_d, cnt + ((kind == 1) ? 1 : 3), (!we) && (kind == 0));
        $display("wb %s: we=%0b adr=%h dat=%h sel=%h", nm, we, adr, dat, sel);
        wait_wb_done(nm);
    endtask

    logic [31:0] fadr [5];
    logic [31:0] fdat [5];
    int          fkind [5];
    int          cs0_before;

    initial begin
        rst = 1'b1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
        if_req_i = 0; if_adr_i = 0;
        repeat (3) @(negedge clk);
        check("reset_wb_ack", 32'(wb_ack_o), 32'h0);
        check("reset_wb_dat", wb_dat_o, 32'h0);
        check("reset_if_ready", 32'(if_ready_o), 32'h0);
        check("reset_if_data", if_data_o, 32'h0);
        check("reset_sram_p0", {sram_cs0, sram_web0, sram_wmask0, 3'b0, sram_addr0}, 32'h0);
        check("reset_sram_p1", {sram_cs1, if_valid_o, if_err_o, wb_err_o, 19'b0, sram_addr1}, 32'h0);
        rst = 1'b0;

        wb_go(1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, "write_deadbeef");
        wb_go(0, BASE + 32'h10, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, "read_deadbeef");
        wb_go(1, BASE + 32'h14, 32'hAAAA_AAAA, 4'hF, 0, 32'h0, "write_aaaa");
        wb_go(1, BASE + 32'h14, 32'h1122_3344, 4'b0101, 0, 32'h0, "write_partial");
        wb_go(0, BASE + 32'h14, 32'h0, 4'hF, 0, 32'hAA22_AA44, "read_partial");
        wb_go(1, BASE + 32'h14, 32'h5555_5555, 4'b0000, 0, 32'h0, "write_sel0");
        wb_go(0, BASE + 32'h14, 32'h0, 4'hF, 0, 32'hAA22_AA44, "read_after_sel0");
        wb_go(0, BASE + 32'h7FC, 32'h0, 4'hF, 0, 32'h0, "read_top_word");

        cs0_before = cs0_count;
        wb_go(1, BASE + 32'h800, 32'h1234_5678, 4'hF, 1, 32'h0, "write_out_of_range");
        wb_go(0, BASE - 32'h4, 32'h0, 4'hF, 1, 32'h0, "read_below_range");
        repeat (3) @(negedge clk);
        check("oor_no_cs0", cs0_count, cs0_before);

        for (int i = 0; i < 4; i++)
            wb_go(1, BASE + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h1111), 4'hF, 0, 32'h0, "fetch_preload");

        for (int i = 0; i < 4; i++) begin
            fadr[i] = BASE + 32'(4 * i);
            fdat[i] = 32'hC0DE_0000 + 32'(i * 32'h1111);
            fkind[i] = 0;
        end
        fadr[4] = BASE + 32'h800; fdat[4] = 32'h0; fkind[4] = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if_req_i = 1'b1; if_adr_i = fadr[i];
            #1;
            check("fetch_ready", 32'(if_ready_o), 32'h1);
            push_if(fkind[i], fdat[i], cnt + 3);
            $display("fetch %0d: adr=%h expect kind=%0d data=%h", i, fadr[i], fkind[i], fdat[i]);
        end
        @(negedge clk);
        if_req_i = 1'b0;
        repeat (4) @(negedge clk);

`ifdef SRAM_BRIDGE_HAZARD_EN
        wb_go(1, BASE + 32'h20, 32'h0BAD_F00D, 4'hF, 0, 32'h0, "hazard_preload");
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = BASE + 32'h20; wb_dat_i = 32'hC0FF_EE00; wb_sel_i = 4'hF;
        if_req_i = 1'b1; if_adr_i = BASE + 32'h20;
        push_wb(0, 32'h0, cnt + 3, 1'b0);
        #1;
        check("hazard_ready_low", 32'(if_ready_o), 32'h0);
        $display("hazard: write+fetch same word %h", BASE + 32'h20);
        @(negedge clk);
        #1;
        check("hazard_ready_high", 32'(if_ready_o), 32'h1);
        push_if(0, 32'hC0FF_EE00, cnt + 3);
        @(negedge clk);
        if_req_i = 1'b0;
        wait_wb_done("hazard_write");
        repeat (4) @(negedge clk);
`endif

        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = BASE + 32'h10; wb_sel_i = 4'hF;
        $display("wb reset_mid_read: adr=%h", BASE + 32'h10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ack", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
        check("midrst_dat", wb_dat_o, 32'h0);
        check("midrst_cs0", 32'(sram_cs0), 32'h0);
        check("midrst_ready", 32'(if_ready_o), 32'h0);
        rst = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        wb_go(0, BASE + 32'h14, 32'h0, 4'hF, 0, 32'hAA22_AA44, "read_after_reset");

        repeat (5) @(negedge clk);
        check("wb_queue_drained", wb_q.size(), 0);
        check("if_queue_drained", if_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cnt);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_wb_bridge.md
# sram_wb_bridge

Bridge that sits directly upstream of the 2 KiB dual-port SRAM macro (active-high chip-select wrapper). Port 0 (RW) is served from a Wishbone classic slave on the data bus. Port 1 (R) is served from a pipelined instruction-fetch request interface. All SRAM-side signals are registered in this block, so the macro samples clean, glitch-free commands on the shared clock.

## Interface
Parameters:
- ADDR_WIDTH, 9, SRAM word-address width; word index is adr[ADDR_WIDTH+1:2]
- BASE_ADDR, 32'h2000_0000, byte base of the SRAM window; must be aligned to 4<<ADDR_WIDTH
- Window size is fixed at 4<<ADDR_WIDTH bytes; an address is in range when adr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]

Ports:
- clk  in  1  system clock; also drives SRAM clk0/clk1 at top level
- rst  in  1  synchronous, active-high reset
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone classic control
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lanes
- wb_dat_o  out  32  read data, held until next read
- wb_ack_o, wb_err_o  out  1  single-cycle termination
- if_req_i  in  1  fetch request, accepted when if_ready_o=1
- if_adr_i  in  32  fetch byte address
- if_ready_o  out  1  fetch accept
- if_valid_o, if_err_o  out  1  fetch response strobes
- if_data_o  out  32  fetch data, valid with if_valid_o
- sram_cs0, sram_web0  out  1  port 0 select (active high), write enable (active low)
- sram_wmask0  out  4  port 0 byte mask
- sram_addr0  out  ADDR_WIDTH  port 0 word address
- sram_din0  out  32  port 0 write data
- sram_dout0  in  32  port 0 read data
- sram_cs1  out  1  port 1 select
- sram_addr1  out  ADDR_WIDTH  port 1 word address
- sram_dout1  in  32  port 1 read data

## Operation
Port 0 FSM: IDLE, ISSUE, WAIT, ACK.
- IDLE, cyc&stb, in range: register cs0=1, web0=!we, wmask0=we?sel:0, addr0, din0. Go to ISSUE.
- IDLE, cyc&stb, out of range: wb_err_o=1 for one cycle. No SRAM access. Go to ACK.
- ISSUE: SRAM captures the command at this edge. cs0 returns to 0 next cycle. Go to WAIT.
- WAIT: at the edge, latch sram_dout0 into wb_dat_o on reads only. Pulse wb_ack_o if cyc is still high. Go to ACK.
- ACK: ack/err deassert; stb is ignored. Go to IDLE.
- Master abort: if cyc drops in ISSUE or WAIT, the SRAM operation still completes and ack is suppressed.
- Write with sel=0: the command is issued with mask 0, memory is unchanged, and ack is normal.

Port 1 fetch pipeline:
- if_req_i & if_ready_o, in range: the next cycle has cs1=1 and addr1 registered; stage-1 valid is set.
- Stage 2 samples sram_dout1 into if_data_o and pulses if_valid_o.
- Out of range: cs1 stays 0 and if_err_o pulses at the same position as if_valid_o would.
- Back-to-back requests are accepted every cycle.
- Responses are returned in order.

## Timing
- Reset values: all outputs 0; wb_dat_o and if_data_o are 0; FSM is IDLE; pipeline valids are cleared.
- Wishbone: request sampled at edge E0 → SRAM samples at E1 → data captured at E2. ack is high during E2..E3. Throughput is one access per 4 cycles.
- Wishbone error: err is high during E0..E1. No SRAM cycle occurs.
- Fetch: request accepted at E0 → if_valid_o high during E2..E3. Latency is 2 cycles; throughput is 1 per cycle.
- SRAM dout is only valid from shortly after the negedge until T_HOLD after the next posedge. Read data must therefore be sampled exactly at E2 and never later.
- Reset mid-operation: the FSM goes to IDLE and all strobes drop next cycle. A write already captured by the SRAM at the prior edge still completes at the negedge; this is accepted behaviour.

## Configuration
Macro SRAM_BRIDGE_HAZARD_EN:
- Defined: if_ready_o is 0 in any cycle where the port-0 command being registered is a write whose word address equals if_adr_i's word address. This prevents a simultaneous write/read to the same word; the fetch is accepted the following cycle.
- Undefined: if_ready_o is held at 1 after reset and no collision check is made. Same-address collisions return undefined fetch data.

## Test plan
- Write 32'hDEAD_BEEF, sel=4'hF, to BASE+0x10, then read it back → ack 2 cycles after sample each time; wb_dat_o=32'hDEAD_BEEF.
- Write 32'h1122_3344, sel=4'b0101, over 32'hAAAA_AAAA → read returns 32'hAA22_AA44.
- Access to BASE+0x800 (out of range) → wb_err_o for 1 cycle; sram_cs0 never asserts; no ack.
- Fetch 4 back-to-back words at BASE+0..0xC → if_valid_o high 4 consecutive cycles starting 2 cycles after the first accept, data in order.
- With SRAM_BRIDGE_HAZARD_EN: Wishbone write to BASE+0x20 coincident with a fetch of BASE+0x20 → if_ready_o low 1 cycle; the fetch returns the new data.
- Assert rst during WAIT of a read → no ack; all outputs 0 next cycle; the next transaction completes normally.
